// File: rtl/seg7_msg_scroller.sv
`default_nettype none
// ============================================================================
// Module   : seg7_msg_scroller
// Purpose  : Runtime-writable 7-segment message buffer scrolled across a
//            multiplexed multi-digit display (hold / fwd / rev / blink).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_msg_scroller #(
    parameter  int MSG_DEPTH  = 16,
    parameter  int NUM_DIGITS = 4,
    parameter  int SEG_W      = 8,
    parameter  int PRESCALE_W = 16,
    localparam int IDX_W      = $clog2(MSG_DEPTH),
    localparam int DSEL_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [IDX_W:0]        msg_len,
    input  logic                  wr_en,
    input  logic [IDX_W:0]        wr_addr,
    input  logic [SEG_W-1:0]      wr_data,
    output logic [SEG_W-1:0]      seg_out,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [IDX_W-1:0]      index,
    output logic                  wrap
);

    localparam logic [1:0]        MODE_HOLD  = 2'b00;
    localparam logic [1:0]        MODE_FWD   = 2'b01;
    localparam logic [1:0]        MODE_REV   = 2'b10;
    localparam logic [1:0]        MODE_BLINK = 2'b11;
    localparam logic [IDX_W:0]    DEPTH_L    = (IDX_W+1)'(MSG_DEPTH);
    localparam logic [DSEL_W-1:0] SCAN_LAST  = DSEL_W'(NUM_DIGITS - 1);

    logic [SEG_W-1:0]      buf_q [MSG_DEPTH];
    logic [SEG_W-1:0]      buf_d [MSG_DEPTH];
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic                  wrap_q, wrap_d;
    logic                  blink_q, blink_d;
    logic [DSEL_W-1:0]     scan_q, scan_d;
    logic [SEG_W-1:0]      seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

    logic                  tick;
    logic [IDX_W:0]        len_eff;
    logic [IDX_W:0]        len_m1;
    logic [IDX_W:0]        rd_sum;
    logic [IDX_W-1:0]      rd_pos;

    // Message buffer write port; display reads below see the pre-write value
    always_comb begin
        for (int i = 0; i < MSG_DEPTH; i++) begin
            buf_d[i] = buf_q[i];
        end
        if (wr_en && !wr_addr[IDX_W]) begin
            buf_d[wr_addr[IDX_W-1:0]] = wr_data;
        end
    end

    always_comb begin
        if (msg_len == '0) begin
            len_eff = (IDX_W+1)'(1);
        end else if (msg_len > DEPTH_L) begin
            len_eff = DEPTH_L;
        end else begin
            len_eff = msg_len;
        end
        len_m1 = len_eff - (IDX_W+1)'(1);
    end

    // Greater-or-equal compare so a lowered prescale never forces a rollover
    always_comb begin
        tick  = (cnt_q >= prescale);
        cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
    end

    always_comb begin
        index_d = index_q;
        wrap_d  = 1'b0;
        if ({1'b0, index_q} >= len_eff) begin
            index_d = '0;
        end else if (tick) begin
            case (mode)
                MODE_FWD: begin
                    if ({1'b0, index_q} == len_m1) begin
                        index_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
                MODE_REV: begin
                    if (index_q == '0) begin
                        index_d = len_m1[IDX_W-1:0];
                        wrap_d  = 1'b1;
                    end else begin
                        index_d = index_q - IDX_W'(1);
                    end
                end
                MODE_HOLD, MODE_BLINK: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        blink_d = 1'b1;
        if (mode == MODE_BLINK) begin
            blink_d = tick ? ~blink_q : blink_q;
        end
    end

    // True modulo: a short message repeats across the remaining digits
    always_comb begin
        scan_d      = (scan_q == SCAN_LAST) ? '0 : scan_q + DSEL_W'(1);
        rd_sum      = {1'b0, index_q} + (IDX_W+1)'(scan_q);
        rd_pos      = IDX_W'(rd_sum % len_eff);
        digit_sel_d = NUM_DIGITS'(1) << scan_q;
        seg_out_d   = blink_q ? buf_q[rd_pos] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            cnt_q       <= '0;
            index_q     <= '0;
            wrap_q      <= 1'b0;
            blink_q     <= 1'b1;
            scan_q      <= '0;
            seg_out_q   <= '0;
            digit_sel_q <= NUM_DIGITS'(1);
        end else begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
            cnt_q       <= cnt_d;
            index_q     <= index_d;
            wrap_q      <= wrap_d;
            blink_q     <= blink_d;
            scan_q      <= scan_d;
            seg_out_q   <= seg_out_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign seg_out   = seg_out_q;
    assign digit_sel = digit_sel_q;
    assign index     = index_q;
    assign wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_msg_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_msg_scroller
// Purpose  : Directed, table-driven self-checking bench for seg7_msg_scroller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_msg_scroller;

    localparam int MSG_DEPTH  = 16;
    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 8;
    localparam int PRESCALE_W = 16;
    localparam int IDX_W      = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            mode;
    logic [PRESCALE_W-1:0] prescale;
    logic [IDX_W:0]        msg_len;
    logic                  wr_en;
    logic [IDX_W:0]        wr_addr;
    logic [SEG_W-1:0]      wr_data;
    logic [SEG_W-1:0]      seg_out;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [IDX_W-1:0]      index;
    logic                  wrap;

    always #5 clk = ~clk;

    seg7_msg_scroller #(
        .MSG_DEPTH  (MSG_DEPTH),
        .NUM_DIGITS (NUM_DIGITS),
        .SEG_W      (SEG_W),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .prescale  (prescale),
        .msg_len   (msg_len),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .seg_out   (seg_out),
        .digit_sel (digit_sel),
        .index     (index),
        .wrap      (wrap)
    );

    // One row: inputs driven at a falling edge, outputs expected one rising edge later
    typedef struct {
        logic                  rst;
        logic [1:0]            mode;
        logic [PRESCALE_W-1:0] ps;
        logic [IDX_W:0]        len;
        logic                  we;
        logic [IDX_W:0]        wa;
        logic [SEG_W-1:0]      wd;
        logic [SEG_W-1:0]      e_seg;
        logic [NUM_DIGITS-1:0] e_dsel;
        logic [IDX_W-1:0]      e_idx;
        logic                  e_wrap;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic add(input int r, input int m, input int p, input int l,
                       input int we, input int wa, input int wd,
                       input int es, input int ed, input int ei, input int ew);
        vec_t v;
        v.rst    = 1'(r);
        v.mode   = 2'(m);
        v.ps     = PRESCALE_W'(p);
        v.len    = (IDX_W+1)'(l);
        v.we     = 1'(we);
        v.wa     = (IDX_W+1)'(wa);
        v.wd     = SEG_W'(wd);
        v.e_seg  = SEG_W'(es);
        v.e_dsel = NUM_DIGITS'(ed);
        v.e_idx  = IDX_W'(ei);
        v.e_wrap = 1'(ew);
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        mode     = 2'b00;
        prescale = '0;
        msg_len  = (IDX_W+1)'(4);
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;

        //   rst m  ps len we wa  wd     seg   dsel idx wrap
        // reset, then a write that reset must swallow
        add(1, 0, 0, 4, 0, 0, 'h00,  'h00, 'h1, 0, 0);
        add(1, 0, 0, 4, 1, 0, 'hFF,  'h00, 'h1, 0, 0);
        // load message while scanning; reads return pre-write contents
        add(0, 0, 0, 4, 1, 0, 'h5B,  'h00, 'h1, 0, 0);
        add(0, 0, 0, 4, 1, 1, 'h4F,  'h00, 'h2, 0, 0);
        add(0, 0, 0, 4, 1, 2, 'h15,  'h00, 'h4, 0, 0);
        add(0, 0, 0, 4, 1, 3, 'h7E,  'h00, 'h8, 0, 0);
        add(0, 0, 0, 4, 0, 0, 'h00,  'h5B, 'h1, 0, 0);
        add(0, 0, 0, 4, 0, 0, 'h00,  'h4F, 'h2, 0, 0);
        add(0, 0, 0, 4, 0, 0, 'h00,  'h15, 'h4, 0, 0);
        add(0, 0, 0, 4, 0, 0, 'h00,  'h7E, 'h8, 0, 0);
        // forward scroll, prescale 2, L=4
        add(0, 1, 2, 4, 0, 0, 'h00,  'h5B, 'h1, 0, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h4F, 'h2, 0, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h15, 'h4, 1, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h5B, 'h8, 1, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h4F, 'h1, 1, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h15, 'h2, 2, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h5B, 'h4, 2, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h4F, 'h8, 2, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h15, 'h1, 3, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h5B, 'h2, 3, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h4F, 'h4, 3, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h15, 'h8, 0, 1);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h5B, 'h1, 0, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h4F, 'h2, 0, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h15, 'h4, 1, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h5B, 'h8, 1, 0);
        add(0, 1, 2, 4, 0, 0, 'h00,  'h4F, 'h1, 1, 0);
        // reverse scroll, tick every cycle, L=3 (shorter than digit count)
        add(0, 2, 0, 3, 0, 0, 'h00,  'h15, 'h2, 0, 0);
        add(0, 2, 0, 3, 0, 0, 'h00,  'h15, 'h4, 2, 1);
        add(0, 2, 0, 3, 0, 0, 'h00,  'h15, 'h8, 1, 0);
        add(0, 2, 0, 3, 0, 0, 'h00,  'h4F, 'h1, 0, 0);
        add(0, 2, 0, 3, 0, 0, 'h00,  'h4F, 'h2, 2, 1);
        add(0, 2, 0, 3, 0, 0, 'h00,  'h4F, 'h4, 1, 0);
        // blink, prescale 1, then back to hold
        add(0, 3, 1, 3, 0, 0, 'h00,  'h4F, 'h8, 1, 0);
        add(0, 3, 1, 3, 0, 0, 'h00,  'h4F, 'h1, 1, 0);
        add(0, 3, 1, 3, 0, 0, 'h00,  'h00, 'h2, 1, 0);
        add(0, 3, 1, 3, 0, 0, 'h00,  'h00, 'h4, 1, 0);
        add(0, 3, 1, 3, 0, 0, 'h00,  'h4F, 'h8, 1, 0);
        add(0, 3, 1, 3, 0, 0, 'h00,  'h4F, 'h1, 1, 0);
        add(0, 3, 1, 3, 0, 0, 'h00,  'h00, 'h2, 1, 0);
        add(0, 0, 1, 3, 0, 0, 'h00,  'h00, 'h4, 1, 0);
        add(0, 0, 1, 3, 0, 0, 'h00,  'h4F, 'h8, 1, 0);
        // shrink to L=1 forces index to 0, then L=4 hold
        add(0, 0, 1, 1, 0, 0, 'h00,  'h5B, 'h1, 0, 0);
        add(0, 0, 1, 4, 0, 0, 'h00,  'h4F, 'h2, 0, 0);
        add(0, 0, 1, 4, 0, 0, 'h00,  'h15, 'h4, 0, 0);
        add(0, 0, 1, 4, 0, 0, 'h00,  'h7E, 'h8, 0, 0);
        add(0, 0, 1, 4, 0, 0, 'h00,  'h5B, 'h1, 0, 0);
        // write buf[1] while it is being read; then out-of-range write
        add(0, 0, 1, 4, 1, 1, 'h06,  'h4F, 'h2, 0, 0);
        add(0, 0, 1, 4, 1, 16,'h77,  'h15, 'h4, 0, 0);
        add(0, 0, 1, 4, 0, 0, 'h00,  'h7E, 'h8, 0, 0);
        add(0, 0, 1, 4, 0, 0, 'h00,  'h5B, 'h1, 0, 0);
        add(0, 0, 1, 4, 0, 0, 'h00,  'h06, 'h2, 0, 0);
        // forward to index 6 with L=8, then shrink to L=4
        add(0, 1, 0, 8, 0, 0, 'h00,  'h15, 'h4, 1, 0);
        add(0, 1, 0, 8, 0, 0, 'h00,  'h00, 'h8, 2, 0);
        add(0, 1, 0, 8, 0, 0, 'h00,  'h15, 'h1, 3, 0);
        add(0, 1, 0, 8, 0, 0, 'h00,  'h00, 'h2, 4, 0);
        add(0, 1, 0, 8, 0, 0, 'h00,  'h00, 'h4, 5, 0);
        add(0, 1, 0, 8, 0, 0, 'h00,  'h5B, 'h8, 6, 0);
        add(0, 1, 0, 4, 0, 0, 'h00,  'h15, 'h1, 0, 0);
        // msg_len = 0 acts as L=1: buf[0] on every digit
        add(0, 0, 0, 0, 0, 0, 'h00,  'h5B, 'h2, 0, 0);
        add(0, 0, 0, 0, 0, 0, 'h00,  'h5B, 'h4, 0, 0);
        add(0, 0, 0, 0, 0, 0, 'h00,  'h5B, 'h8, 0, 0);
        add(0, 1, 0, 0, 0, 0, 'h00,  'h5B, 'h1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 'h00,  'h5B, 'h2, 0, 1);
        // reset mid-scroll with a write pending clears everything
        add(0, 1, 0, 4, 0, 0, 'h00,  'h15, 'h4, 1, 0);
        add(0, 1, 0, 4, 0, 0, 'h00,  'h5B, 'h8, 2, 0);
        add(1, 1, 0, 4, 1, 2, 'hAA,  'h00, 'h1, 0, 0);
        add(0, 0, 0, 4, 0, 0, 'h00,  'h00, 'h1, 0, 0);
        add(0, 0, 0, 4, 0, 0, 'h00,  'h00, 'h2, 0, 0);
        add(0, 0, 0, 4, 0, 0, 'h00,  'h00, 'h4, 0, 0);
        add(0, 0, 0, 4, 0, 0, 'h00,  'h00, 'h8, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            rst      = vq[i].rst;
            mode     = vq[i].mode;
            prescale = vq[i].ps;
            msg_len  = vq[i].len;
            wr_en    = vq[i].we;
            wr_addr  = vq[i].wa;
            wr_data  = vq[i].wd;
            @(negedge clk);
            check("seg_out",   i, 32'(seg_out),   32'(vq[i].e_seg));
            check("digit_sel", i, 32'(digit_sel), 32'(vq[i].e_dsel));
            check("index",     i, 32'(index),     32'(vq[i].e_idx));
            check("wrap",      i, 32'(wrap),      32'(vq[i].e_wrap));
        end

        // Lowering prescale below the running count ticks on the next cycle
        rst      = 1'b0;
        mode     = 2'b01;
        prescale = PRESCALE_W'(5);
        msg_len  = (IDX_W+1)'(4);
        wr_en    = 1'b0;
        repeat (3) @(negedge clk);
        check("ps_before_lower", 100, 32'(index), 32'd0);
        prescale = PRESCALE_W'(1);
        @(negedge clk);
        check("ps_lower_tick",   101, 32'(index), 32'd1);
        check("ps_lower_wrap",   101, 32'(wrap),  32'd0);
        @(negedge clk);
        check("ps_after_idle",   102, 32'(index), 32'd1);
        @(negedge clk);
        check("ps_after_tick",   103, 32'(index), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
